// File: rtl/debug_run_sequencer.sv
// debug_run_sequencer: run-mode controller between the UART debug unit and
// the MIPS pipeline. Gates the pipeline enable in continuous or single-step
// mode and, after each step or after HALT, streams a register-bank dump over
// UART TX (four bytes per word, MSB first).
// Optional feature macro: CYCLE_COUNT_EN -- counts enabled pipeline cycles and
// appends the count as one extra dump word.
//
// TX handshake: o_tx_start is a one-cycle pulse that launches o_tx_data; the
// byte is held unchanged until the UART answers with a one-cycle i_tx_done.
// i_tx_done seen in any state other than DUMP_WAIT is ignored.
module debug_run_sequencer #(
  parameter int SIZE_TRAMA     = 8,
  parameter int SIZE_WORD      = 32,
  parameter int N_DUMP_WORDS   = 32,
  parameter int DUMP_ADDR_BITS = 5
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_start_cont,
  input  logic                      i_start_step,
  input  logic                      i_step_req,
  input  logic                      i_halt,
  input  logic [SIZE_WORD-1:0]      i_dump_data,
  input  logic                      i_tx_done,
  output logic                      o_mips_en,
  output logic [DUMP_ADDR_BITS-1:0] o_dump_addr,
  output logic [SIZE_TRAMA-1:0]     o_tx_data,
  output logic                      o_tx_start,
  output logic                      o_busy,
  output logic [3:0]                o_state
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] RUN_CONT  = 4'd1;
  localparam logic [3:0] STEP_WAIT = 4'd2;
  localparam logic [3:0] STEP_EXEC = 4'd3;
  localparam logic [3:0] DUMP_LOAD = 4'd4;
  localparam logic [3:0] DUMP_SEND = 4'd5;
  localparam logic [3:0] DUMP_WAIT = 4'd6;

  // Word counter is one bit wider than the address so it can index the
  // optional trailing cycle-count word without disturbing o_dump_addr.
  localparam int WORD_W = DUMP_ADDR_BITS + 1;
  localparam logic [WORD_W-1:0] LAST_BANK = WORD_W'(N_DUMP_WORDS - 1);
`ifdef CYCLE_COUNT_EN
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(N_DUMP_WORDS);
`else
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(N_DUMP_WORDS - 1);
`endif

  logic [3:0]                state_q, state_d;
  logic                      mips_en_q, mips_en_d;
  logic [DUMP_ADDR_BITS-1:0] dump_addr_q, dump_addr_d;
  logic [SIZE_TRAMA-1:0]     tx_data_q, tx_data_d;
  logic                      tx_start_q, tx_start_d;
  logic                      busy_q, busy_d;
  logic [SIZE_WORD-1:0]      shift_q, shift_d;
  logic [1:0]                byte_cnt_q, byte_cnt_d;
  logic [WORD_W-1:0]         word_q, word_d;
  logic                      halt_seen_q, halt_seen_d;
`ifdef CYCLE_COUNT_EN
  logic [SIZE_WORD-1:0]      cycle_cnt_q, cycle_cnt_d;
`endif

  // Next-state and registered-output computation for the run/dump FSM.
  always_comb begin
    state_d     = state_q;
    dump_addr_d = dump_addr_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    shift_d     = shift_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    halt_seen_d = halt_seen_q;
`ifdef CYCLE_COUNT_EN
    cycle_cnt_d = mips_en_q ? cycle_cnt_q + 1'b1 : cycle_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        // Continuous start wins over step start when both arrive together.
        if (i_start_cont || i_start_step) begin
          state_d     = i_start_cont ? RUN_CONT : STEP_WAIT;
          halt_seen_d = 1'b0;
`ifdef CYCLE_COUNT_EN
          cycle_cnt_d = '0;
`endif
        end
      end
      RUN_CONT: begin
        if (i_halt) begin
          halt_seen_d = 1'b1;
          word_d      = '0;
          dump_addr_d = '0;
          state_d     = DUMP_LOAD;
        end
      end
      STEP_WAIT: begin
        if (i_halt)          state_d = IDLE;
        else if (i_step_req) state_d = STEP_EXEC;
      end
      STEP_EXEC: begin
        // Halt is observed one cycle after the step edge.
        halt_seen_d = i_halt;
        word_d      = '0;
        dump_addr_d = '0;
        state_d     = DUMP_LOAD;
      end
      DUMP_LOAD: begin
        shift_d    = i_dump_data;
`ifdef CYCLE_COUNT_EN
        if (word_q == WORD_W'(N_DUMP_WORDS)) shift_d = cycle_cnt_q;
`endif
        byte_cnt_d = '0;
        state_d    = DUMP_SEND;
      end
      DUMP_SEND: begin
        tx_data_d  = shift_q[SIZE_WORD-1 -: SIZE_TRAMA];
        tx_start_d = 1'b1;
        state_d    = DUMP_WAIT;
      end
      DUMP_WAIT: begin
        if (i_tx_done) begin
          shift_d    = shift_q << SIZE_TRAMA;
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q != 2'd3) begin
            state_d = DUMP_SEND;
          end else if (word_q != LAST_WORD) begin
            // Address stops at the last bank word; the count word reuses it.
            if (word_q < LAST_BANK) dump_addr_d = dump_addr_q + 1'b1;
            word_d  = word_q + 1'b1;
            state_d = DUMP_LOAD;
          end else begin
            dump_addr_d = '0;
            word_d      = '0;
            state_d     = halt_seen_q ? IDLE : STEP_WAIT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    mips_en_d = (state_d == RUN_CONT) || (state_d == STEP_EXEC);
    busy_d    = (state_d != IDLE);
  end

  // State and output registers; reset aborts any dump in flight.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= IDLE;
      mips_en_q   <= 1'b0;
      dump_addr_q <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      shift_q     <= '0;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      halt_seen_q <= 1'b0;
`ifdef CYCLE_COUNT_EN
      cycle_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mips_en_q   <= mips_en_d;
      dump_addr_q <= dump_addr_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      busy_q      <= busy_d;
      shift_q     <= shift_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      halt_seen_q <= halt_seen_d;
`ifdef CYCLE_COUNT_EN
      cycle_cnt_q <= cycle_cnt_d;
`endif
    end
  end

  assign o_state     = state_q;
  assign o_mips_en   = mips_en_q;
  assign o_dump_addr = dump_addr_q;
  assign o_tx_data   = tx_data_q;
  assign o_tx_start  = tx_start_q;
  assign o_busy      = busy_q;

endmodule
